// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: application/display bundle for the 7-segment scan controller.
//   load, data, dp_mask, lz_blank : application side, captured on load
//   an, seg, dp, frame            : display side, all active-low except frame
// master = application/display owner, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  modport master (
    output load, data, dp_mask, lz_blank,
    input  an, seg, dp, frame
  );

  modport slave (
    input  load, data, dp_mask, lz_blank,
    output an, seg, dp, frame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// 7-segment display.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : seg_scan_ctrl_if.slave (load/data/dp_mask/lz_blank in,
//              an/seg/dp/frame out)
// A load lands in shadow registers; shadow moves to the active set only at the
// frame boundary (end of the digit-3 slot) so a frame never mixes two values.
// Each DIV-cycle slot starts with BLANK all-off cycles to suppress ghosting.

// Per-digit decode: BCD nibble to active-low abcdefg, with a force-off input.
module seg_scan_dec (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (nib)
        4'd0:    seg = 7'b0000001;
        4'd1:    seg = 7'b1001111;
        4'd2:    seg = 7'b0010010;
        4'd3:    seg = 7'b0000110;
        4'd4:    seg = 7'b1001100;
        4'd5:    seg = 7'b0100100;
        4'd6:    seg = 7'b0100000;
        4'd7:    seg = 7'b0001111;
        4'd8:    seg = 7'b0000000;
        4'd9:    seg = 7'b0000100;
        default: seg = 7'b1111111;
      endcase
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int NUM_DIG = 4;
  localparam int CW      = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [15:0] sh_data, ac_data;
  logic [3:0]  sh_dp,   ac_dp;
  logic        sh_lz,   ac_lz;

  logic slot_end, boundary, drive;
  assign slot_end = (cnt == CW'(DIV - 1));
  assign boundary = slot_end && (idx == 2'd3);
  assign drive    = (cnt >= CW'(BLANK));

  // Decoded segments for every digit; the scan just picks one by idx.
  logic [NUM_DIG-1:0][6:0] dig_seg;
  logic [NUM_DIG-1:0]      nz_above;  // some nibble in i..3 is non-zero
  logic [NUM_DIG-1:0]      lz_off;

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      assign nz_above[g] = |ac_data[15:4*g];
      // Digit 0 always shows, so a value of zero still displays "0".
      if (g == 0) begin : g_lsd
        assign lz_off[g] = 1'b0;
      end else begin : g_msd
        assign lz_off[g] = ac_lz && !nz_above[g];
      end
      seg_scan_dec u_dec (
        .nib   (ac_data[4*g +: 4]),
        .blank (lz_off[g]),
        .seg   (dig_seg[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_lz     <= 1'b0;
      ac_data   <= '0;
      ac_dp     <= '0;
      ac_lz     <= 1'b0;
      bus.an    <= 4'b1111;
      bus.seg   <= 7'b1111111;
      bus.dp    <= 1'b1;
      bus.frame <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx + 2'd1;

      // Active takes the pre-edge shadow, so a load on the boundary cycle
      // itself waits for the next frame.
      if (boundary) begin
        ac_data <= sh_data;
        ac_dp   <= sh_dp;
        ac_lz   <= sh_lz;
      end
      if (bus.load) begin
        sh_data <= bus.data;
        sh_dp   <= bus.dp_mask;
        sh_lz   <= bus.lz_blank;
      end

      // Outputs are a registered view of the current (pre-edge) cnt/idx.
      bus.frame <= boundary;
      if (drive) begin
        bus.an  <= ~(4'b0001 << idx);
        bus.seg <= dig_seg[idx];
        bus.dp  <= ~ac_dp[idx];
      end else begin
        bus.an  <= 4'b1111;
        bus.seg <= 7'b1111111;
        bus.dp  <= 1'b1;
      end
    end
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It latches a 16-bit BCD value through a load strobe and applies it only at frame boundaries, so the display never tears. It then cycles the four digit anodes, decoding each digit's nibble to active-low segments. It sits between the application logic and the board display pins, sharing one segment bus among four digits.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range ≥ 4.
- BLANK, 16: anti-ghosting cycles at the start of each slot with all outputs off; legal range 1 ≤ BLANK < DIV.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  capture strobe; when high at an edge, data, dp_mask and lz_blank are captured into the shadow registers.
- data  in  16  four BCD nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_mask  in  4  decimal point enable per digit, 1 = lit.
- lz_blank  in  1  leading-zero blanking enable.
- an  out  4  digit anodes, active-low; bit i selects digit i.
- seg  out  7  segments, active-low; seg[6]=a through seg[0]=g.
- dp  out  1  decimal point, active-low.
- frame  out  1  one-cycle pulse marking the end of the digit-3 slot.

## Operation
- State:
  - slot counter cnt, range 0..DIV-1;
  - digit index idx, range 0..3;
  - shadow registers: data, dp_mask, lz_blank;
  - active registers: the same three fields.
- Counter behaviour:
  - cnt increments every cycle.
  - At cnt==DIV-1, cnt returns to 0 and idx advances. idx wraps from 3 to 0.
- Frame boundary: the edge where cnt==DIV-1 and idx==3. At this edge the active registers take the pre-edge shadow contents.
- Load:
  - Captures into the shadow registers only. The last load before a boundary wins.
  - A load on the boundary cycle itself lands in shadow and is applied at the following boundary.
- Blank phase, cnt < BLANK: an=1111, seg=1111111, dp=1.
- Drive phase:
  - an has only bit idx low.
  - seg = decode of active nibble idx.
  - dp = ~active dp_mask[idx].
- Decode, active-low, abcdefg:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Nibbles 10–15 decode to 1111111.
- Leading-zero blanking:
  - Applies when active lz_blank=1.
  - Digit i (i=3,2,1) is blanked when nibbles i..3 are all 0. Digit 0 is never blanked.
  - A blanked digit forces seg=1111111. Its anode and dp behave normally.
- Outputs an, seg, dp and frame are registered: they reflect the cnt/idx state of the previous cycle.
- frame is high for exactly the one cycle after the boundary edge.

## Timing
- Reset values:
  - cnt=0, idx=0.
  - All shadow and active registers = 0.
  - an=1111, seg=1111111, dp=1, frame=0.
- rst has priority over load and over the boundary update. Asserting rst mid-slot returns all state to reset values at that edge.
- After reset release, with state (cnt, idx) = (0, 0):
  - Outputs stay blank for BLANK cycles.
  - Digit 0 is then driven showing "0" (seg=0000001), since active data resets to 0.
- Frame period: 4·DIV cycles. Each digit is driven DIV−BLANK cycles per slot.
- Load-to-display latency: up to 4·DIV+1 cycles.
  - Measure from the load edge to the first boundary edge, plus one register stage.
  - Digit 0 becomes visible BLANK+1 cycles after the boundary edge.
- The anode never changes within a drive phase.
- Every idx change is preceded on the outputs by BLANK all-off cycles.

## Test plan
Run with DIV=8 and BLANK=2.
1. Reset, then release:
   - an=1111 for 2 cycles;
   - then an=1110 with seg=0000001 for 6 cycles;
   - then an=1111, then an=1101 …
   - frame pulses every 32 cycles.
2. load with data=16'h1234 and dp_mask=4'b0100 mid-frame:
   - The old value persists until the boundary.
   - In the next frame: digit0 seg=1001100 (4), digit1 0000110 (3), digit2 0010010 (2) with dp=0, digit3 1001111 (1).
3. lz_blank=1 with data=16'h0070:
   - digit3 and digit2 have an asserted but seg=1111111;
   - digit1 shows 0001111 (7);
   - digit0 shows 0000001 (0).
   - data=16'h0000 with lz_blank=1: only digit0 shows 0000001.
4. data=16'h00AF:
   - digits 0 and 1 show seg=1111111 while their anodes are asserted.
5. load 16'h1111 three cycles before the boundary and load 16'h2222 on the boundary cycle:
   - The next frame shows 1111.
   - The frame after that shows 2222.
6. Assert rst for 1 cycle during the digit-2 drive phase:
   - The next outputs are an=1111, seg=1111111, dp=1, frame=0.
   - The scan restarts at digit 0, and active data = 0.
